// File: rtl/uart_pixel_assembler.sv
// Frame-sync hunter and pixel packer between a UART RX byte stream and a
// ready/valid pixel consumer, with a show-ahead FIFO tagged with sof/eol.
module uart_pixel_assembler #(
  parameter int         CHANNELS   = 3,
  parameter int         CH_BITS    = 8,
  parameter int         IMG_W      = 640,
  parameter int         IMG_H      = 480,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] SYNC0      = 8'hA5,
  parameter logic [7:0] SYNC1      = 8'h5A
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset_n,
  input  logic [7:0]                  i_byte,
  input  logic                        i_byte_valid,
  input  logic                        i_clear,
  input  logic                        i_ready,
  output logic [CHANNELS*CH_BITS-1:0] o_data,
  output logic                        o_sof,
  output logic                        o_eol,
  output logic                        o_valid,
  output logic                        o_frame_done,
  output logic                        o_overflow,
  output logic                        o_busy
);

  localparam int PIX_W = CHANNELS * CH_BITS;
  localparam int BPP   = PIX_W / 8;
  localparam int BC_W  = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int X_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int Y_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = PIX_W + 2;

  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] SYNC    = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;

  logic [1:0]       state_r, state_s;
  logic [BC_W-1:0]  byte_cnt_r;
  logic [X_W-1:0]   x_r;
  logic [Y_W-1:0]   y_r;
  logic [PIX_W-1:0] asm_r;
  logic [EW-1:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [AW:0]      count_r;
  logic             overflow_r, frame_done_r;

  logic             byte_ev_s, complete_s, x_last_s, y_last_s, last_s;
  logic             full_s, pop_s, push_s, drop_s;
  logic [PIX_W-1:0] pixel_s;
  logic [EW-1:0]    head_s;

  // MSB-first packing: shift the new byte in at the bottom, truncate to pixel width
  assign pixel_s    = PIX_W'({asm_r, i_byte});
  assign byte_ev_s  = i_byte_valid && (state_r == PAYLOAD);
  assign complete_s = byte_ev_s && (byte_cnt_r == BC_W'(BPP - 1));
  assign x_last_s   = (x_r == X_W'(IMG_W - 1));
  assign y_last_s   = (y_r == Y_W'(IMG_H - 1));
  assign last_s     = x_last_s && y_last_s;
  assign full_s     = (count_r == (AW+1)'(FIFO_DEPTH));
  assign pop_s      = (count_r != '0) && i_ready;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push
  assign push_s     = complete_s && (!full_s || pop_s);
  assign drop_s     = complete_s && full_s && !pop_s;

  assign head_s       = mem_r[rd_ptr_r];
  assign o_data       = head_s[PIX_W-1:0];
  assign o_eol        = head_s[PIX_W];
  assign o_sof        = head_s[PIX_W+1];
  assign o_valid      = (count_r != '0);
  assign o_frame_done = frame_done_r;
  assign o_overflow   = overflow_r;
  assign o_busy       = (state_r != HUNT);

  // Next-state decode; only strobed bytes move the FSM
  always_comb begin
    state_s = state_r;
    if (i_byte_valid) begin
      case (state_r)
        HUNT: begin
          if (i_byte == SYNC0) state_s = SYNC;
          else                 state_s = HUNT;
        end
        SYNC: begin
          if (i_byte == SYNC1)      state_s = PAYLOAD;
          else if (i_byte == SYNC0) state_s = SYNC;
          else                      state_s = HUNT;
        end
        PAYLOAD: begin
          if (complete_s && last_s) state_s = HUNT;
          else                      state_s = PAYLOAD;
        end
        default: state_s = HUNT;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Control state, geometry counters, FIFO pointers and status flags
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n || i_clear) begin
      state_r      <= HUNT;
      byte_cnt_r   <= '0;
      x_r          <= '0;
      y_r          <= '0;
      asm_r        <= '0;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      overflow_r   <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      frame_done_r <= complete_s && last_s;
      if (drop_s) overflow_r <= 1'b1;
      if (byte_ev_s) begin
        asm_r      <= pixel_s;
        byte_cnt_r <= complete_s ? '0 : byte_cnt_r + BC_W'(1);
      end
      // Geometry advances even for dropped pixels to stay frame-aligned
      if (complete_s) begin
        if (x_last_s) begin
          x_r <= '0;
          y_r <= y_last_s ? '0 : y_r + Y_W'(1);
        end else begin
          x_r <= x_r + X_W'(1);
        end
      end
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Pixel storage; contents are don't-care while empty, so no reset
  always_ff @(posedge clk_clk) begin
    if (push_s) mem_r[wr_ptr_r] <= {(x_r == '0) && (y_r == '0), x_last_s, pixel_s};
  end

endmodule
